fmap_bank_ctrl: RTL and testbench

// - Responder side of the fmap-bank interface driven by the conv layer engines.
// - Owns the 32K x 8 feature-map RAM and serves the engine read and write ports with a fixed 2-cycle read latency.
// - Sequences one layer run: init pulse out, then waits for done back.
// - Ping-pongs the two 16K halves so one layer's output (logical 0x4000) becomes the next layer's input (logical 0x0000).
// - Provides a host load/readback port while idle.

---
 rtl/fmap_bank_if.sv | 20 ++
 rtl/fmap_bank_ctrl.sv | 75 +++++++
 tb/tb_fmap_bank_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fmap_bank_if.sv
// fmap_bank_if: run control, engine RAM ports and host port of the feature-map bank
interface fmap_bank_if #(
  parameter int AW = 15,
  parameter int DW = 8
);
  logic start, swap_en, bank_clr, layer_init, layer_done, busy, done, bank_sel;
  logic [AW-1:0] fbank_raddr, fbank_waddr, host_addr;
  logic fbank_ren, fbank_wen, host_we, host_re, host_rvalid, host_ready;
  logic [DW-1:0] fdata_r, fdata_w, host_wdata, host_rdata;
  modport master (
    output start, swap_en, bank_clr, layer_done, fbank_raddr, fbank_ren, fbank_waddr, fdata_w,
           fbank_wen, host_addr, host_wdata, host_we, host_re,
    input  layer_init, busy, done, bank_sel, fdata_r, host_rdata, host_rvalid, host_ready
  );
  modport slave (
    input  start, swap_en, bank_clr, layer_done, fbank_raddr, fbank_ren, fbank_waddr, fdata_w,
           fbank_wen, host_addr, host_wdata, host_we, host_re,
    output layer_init, busy, done, bank_sel, fdata_r, host_rdata, host_rvalid, host_ready
  );
endinterface

// File: rtl/fmap_bank_ctrl.sv
// fmap_bank_ctrl: feature-map RAM owner with layer-run sequencing and ping-pong bank mapping
module fmap_bank_ctrl #(
  parameter int AW = 15,
  parameter int DW = 8,
  parameter int RD_LATENCY = 2
) (
  input logic clk,
  input logic rstn,
  fmap_bank_if.slave bus
);
  typedef enum logic [1:0] {IDLE, INIT, RUN, FINISH} state_t;
  state_t state, state_nxt;
  logic bank_sel_q, swap_q, idle, run, rd_en, wr_en, eng_q, host_q;
  logic [AW-1:0] rd_addr, wr_addr, bank_mask;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_q, wr_data;
  if (RD_LATENCY != 2) begin : g_lat
    $error("fmap_bank_ctrl supports RD_LATENCY = 2 only");
  end
  // Engine and host never own the RAM in the same state, so they share one read and one write port
  assign idle = state == IDLE && rstn;
  assign run = state == RUN && rstn;
  assign bank_mask = {bank_sel_q, {(AW-1){1'b0}}};
  assign rd_en = run ? bus.fbank_ren : idle & bus.host_re;
  assign wr_en = run ? bus.fbank_wen : idle & bus.host_we;
  assign rd_addr = (run ? bus.fbank_raddr : bus.host_addr) ^ bank_mask;
  assign wr_addr = (run ? bus.fbank_waddr : bus.host_addr) ^ bank_mask;
  assign wr_data = run ? bus.fdata_w : bus.host_wdata;
  always_ff @(posedge clk)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.start ? INIT : IDLE;
      INIT:    state_nxt = RUN;
      RUN:     state_nxt = bus.layer_done ? FINISH : RUN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      bank_sel_q <= 1'b0;
      swap_q <= 1'b0;
    end else if (idle) begin
      if (bus.bank_clr) bank_sel_q <= 1'b0;
      if (bus.start) swap_q <= bus.swap_en;
    end else if (state == FINISH && swap_q) begin
      bank_sel_q <= ~bank_sel_q;
    end
  // Nonblocking write next to the registered read gives read-first on collisions
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_q <= mem[rd_addr];
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      eng_q <= 1'b0;
      host_q <= 1'b0;
      bus.host_rvalid <= 1'b0;
      bus.fdata_r <= '0;
      bus.host_rdata <= '0;
    end else begin
      eng_q <= run & bus.fbank_ren;
      host_q <= idle & bus.host_re;
      bus.host_rvalid <= host_q;
      if (eng_q) bus.fdata_r <= rd_q;
      if (host_q) bus.host_rdata <= rd_q;
    end
  assign bus.layer_init = state == INIT;
  assign bus.done = state == FINISH;
  assign bus.busy = state != IDLE;
  assign bus.host_ready = idle;
  assign bus.bank_sel = bank_sel_q;
endmodule

// File: tb/tb_fmap_bank_ctrl.sv
// tb_fmap_bank_ctrl: random layer runs checked against a phase/bank/memory model with a read scoreboard
module tb_fmap_bank_ctrl;
  logic clk = 0, rstn = 0;
  always #5 clk = ~clk;
  fmap_bank_if b();
  fmap_bank_ctrl dut (.clk(clk), .rstn(rstn), .bus(b));
  typedef enum {P_IDLE, P_INIT, P_RUN, P_FIN} ph_t;
  typedef struct packed {
    logic [14:0] ra, wa, ha;
    logic [7:0] wd, hwd;
    logic ren, wen, hwe, hre, st, sw, clr, ld;
  } stim_t;
  typedef struct {int due; logic [7:0] d; bit host; bit dc;} exp_t;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] ref_mem [int];
  logic ref_bank = 0, swap_l = 0;
  ph_t ph = P_IDLE;
  exp_t q[$];
  logic [7:0] eng_last = 0;
  bit eng_known = 1, mon_en = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input stim_t s);
    b.fbank_raddr = s.ra; b.fbank_ren = s.ren; b.fbank_waddr = s.wa; b.fbank_wen = s.wen;
    b.fdata_w = s.wd; b.host_addr = s.ha; b.host_wdata = s.hwd; b.host_we = s.hwe;
    b.host_re = s.hre; b.start = s.st; b.swap_en = s.sw; b.bank_clr = s.clr; b.layer_done = s.ld;
  endtask
  task automatic push_rd(input logic [14:0] phys, input bit host);
    exp_t e;
    e.due = cyc + 2;
    e.host = host;
    e.dc = !ref_mem.exists(int'(phys));
    e.d = e.dc ? 8'h00 : ref_mem[int'(phys)];
    q.push_back(e);
  endtask
  // One clock of stimulus; the model applies the run-phase rules and checks the control outputs
  task automatic step(input stim_t s);
    logic [14:0] m;
    m = {ref_bank, 14'b0};
    drive(s);
    if (ph == P_RUN) begin
      if (s.ren) push_rd(s.ra ^ m, 0);
      if (s.wen) ref_mem[int'(s.wa ^ m)] = s.wd;
    end
    if (ph == P_IDLE) begin
      if (s.hre) push_rd(s.ha ^ m, 1);
      if (s.hwe) ref_mem[int'(s.ha ^ m)] = s.hwd;
    end
    case (ph)
      P_IDLE: begin
        if (s.clr) ref_bank = 0;
        if (s.st) begin ph = P_INIT; swap_l = s.sw; end
      end
      P_INIT: ph = P_RUN;
      P_RUN: if (s.ld) ph = P_FIN;
      default: begin ph = P_IDLE; if (swap_l) ref_bank = ~ref_bank; end
    endcase
    tick();
    drive('0);
    chk("layer_init", 32'(b.layer_init), 32'(ph == P_INIT));
    chk("done", 32'(b.done), 32'(ph == P_FIN));
    chk("busy", 32'(b.busy), 32'(ph != P_IDLE));
    chk("host_ready", 32'(b.host_ready), 32'(ph == P_IDLE));
    chk("bank_sel", 32'(b.bank_sel), 32'(ref_bank));
  endtask
  function automatic logic [14:0] ra_rand();
    logic [14:0] a = '0;
    a[14] = 1'($urandom_range(0, 1));
    a[3:0] = 4'($urandom_range(0, 15));
    return a;
  endfunction
  function automatic stim_t rnd_stim();
    stim_t s = '0;
    s.ra = ra_rand(); s.wa = ra_rand(); s.ha = ra_rand();
    s.wd = 8'($urandom); s.hwd = 8'($urandom);
    s.ren = 1'($urandom); s.wen = 1'($urandom); s.hwe = 1'($urandom); s.hre = 1'($urandom);
    return s;
  endfunction
  always @(negedge clk)
    if (!rstn) begin
      eng_last = 0;
      eng_known = 1;
    end else if (mon_en) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("host_rvalid", 32'(b.host_rvalid), 32'(e.host));
        if (e.host && !e.dc) chk("host_rdata", 32'(b.host_rdata), 32'(e.d));
        if (!e.host && !e.dc) chk("fdata_r", 32'(b.fdata_r), 32'(e.d));
        if (!e.host) begin eng_last = e.d; eng_known = !e.dc; end
      end else begin
        chk("host_rvalid_quiet", 32'(b.host_rvalid), 0);
        if (eng_known) chk("fdata_r_hold", 32'(b.fdata_r), 32'(eng_last));
      end
    end
  initial begin
    stim_t s;
    drive('0);
    repeat (3) tick();
    chk("rst_busy", 32'(b.busy), 0);
    chk("rst_layer_init", 32'(b.layer_init), 0);
    chk("rst_done", 32'(b.done), 0);
    chk("rst_host_ready", 32'(b.host_ready), 0);
    chk("rst_host_rvalid", 32'(b.host_rvalid), 0);
    chk("rst_fdata_r", 32'(b.fdata_r), 0);
    chk("rst_host_rdata", 32'(b.host_rdata), 0);
    chk("rst_bank_sel", 32'(b.bank_sel), 0);
    rstn = 1;
    mon_en = 1;
    tick();
    chk("host_ready_after_rst", 32'(b.host_ready), 1);
    s = '0; s.ha = 15'h3; s.hwe = 1; s.hwd = 8'hA5; step(s);
    s = '0; s.ha = 15'h3; s.hre = 1; step(s);
    s = '0; s.ha = 15'h10; s.hwe = 1; s.hwd = 8'h11; step(s);
    s.ha = 15'h1; s.hwd = 8'h71; step(s);
    s.ha = 15'h2; s.hwd = 8'h72; step(s);
    s = '0; s.st = 1; s.sw = 1; step(s);
    s = '0; step(s);
    s = '0; s.wa = 15'h4000; s.wen = 1; s.wd = 8'h3C; step(s);
    s = '0; s.ra = 15'h10; s.ren = 1; s.wa = 15'h10; s.wen = 1; s.wd = 8'h22; step(s);
    s = '0; s.ra = 15'h10; s.ren = 1; step(s);
    for (int i = 1; i <= 3; i++) begin s = '0; s.ra = 15'(i); s.ren = 1; step(s); end
    s = '0; s.ha = 15'h3; s.hwe = 1; s.hwd = 8'hFF; s.st = 1; step(s);
    s = '0; s.ld = 1; step(s);
    s = '0; step(s);
    s = '0; s.ha = 15'h0; s.hre = 1; step(s);
    s.ha = 15'h4003; step(s);
    for (int i = 0; i < 32; i++) begin
      s = '0; s.ha = {1'(i >> 4), 10'b0, 4'(i)}; s.hwe = 1; s.hwd = 8'($urandom); step(s);
    end
    repeat (15) begin
      repeat ($urandom_range(1, 4)) begin s = rnd_stim(); s.clr = ($urandom_range(0, 7) == 0); step(s); end
      s = rnd_stim(); s.st = 1; s.sw = 1'($urandom); s.clr = ($urandom_range(0, 3) == 0); step(s);
      s = rnd_stim(); s.ld = 1'($urandom); s.st = 1'($urandom); step(s);
      repeat ($urandom_range(1, 8)) begin s = rnd_stim(); s.st = 1'($urandom); step(s); end
      s = rnd_stim(); s.ld = 1; step(s);
      s = rnd_stim(); s.st = 1'($urandom); step(s);
    end
    // Abort a run with reset; data written before it must survive
    s = '0; s.st = 1; s.sw = 1; s.clr = 1; step(s);
    s = '0; step(s);
    s = '0; s.wa = 15'h5; s.wen = 1; s.wd = 8'h5A; step(s);
    s = '0; step(s); step(s);
    rstn = 0;
    q.delete();
    tick();
    ph = P_IDLE; ref_bank = 0; swap_l = 0;
    chk("midrst_busy", 32'(b.busy), 0);
    chk("midrst_bank_sel", 32'(b.bank_sel), 0);
    chk("midrst_done", 32'(b.done), 0);
    tick();
    chk("midrst_done2", 32'(b.done), 0);
    rstn = 1;
    tick();
    chk("midrst_host_ready", 32'(b.host_ready), 1);
    s = '0; s.ha = 15'h5; s.hre = 1; step(s);
    s = '0; step(s); step(s); step(s);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
